// File: rtl/axi_rab_pkg.sv
// Constants and FSM state type shared by the RAB AXI helper blocks.
package axi_rab_pkg;

    localparam logic [1:0]  RESP_SLVERR      = 2'b10;
    localparam logic [31:0] ERR_DATA_PATTERN = 32'hDEADBEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DROP = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi4_r_sender_if.sv
// Drop-request side plus slave- and master-facing AXI4 R channels of axi4_r_sender.
interface axi4_r_sender_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 4
);
    logic [AXI_ID_WIDTH-1:0]   trans_id;
    logic [7:0]                trans_len;
    logic                      trans_drop;
    logic                      drop_ready;

    logic [AXI_ID_WIDTH-1:0]   s_axi4_rid;
    logic [1:0]                s_axi4_rresp;
    logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata;
    logic                      s_axi4_rlast;
    logic                      s_axi4_rvalid;
    logic [AXI_USER_WIDTH-1:0] s_axi4_ruser;
    logic                      s_axi4_rready;

    logic [AXI_ID_WIDTH-1:0]   m_axi4_rid;
    logic [1:0]                m_axi4_rresp;
    logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata;
    logic                      m_axi4_rlast;
    logic                      m_axi4_rvalid;
    logic [AXI_USER_WIDTH-1:0] m_axi4_ruser;
    logic                      m_axi4_rready;

    // The sender block itself
    modport slave (
        input  trans_id, trans_len, trans_drop, s_axi4_rready,
        input  m_axi4_rid, m_axi4_rresp, m_axi4_rdata, m_axi4_rlast, m_axi4_rvalid, m_axi4_ruser,
        output drop_ready, m_axi4_rready,
        output s_axi4_rid, s_axi4_rresp, s_axi4_rdata, s_axi4_rlast, s_axi4_rvalid, s_axi4_ruser
    );

    // Environment around the sender
    modport master (
        output trans_id, trans_len, trans_drop, s_axi4_rready,
        output m_axi4_rid, m_axi4_rresp, m_axi4_rdata, m_axi4_rlast, m_axi4_rvalid, m_axi4_ruser,
        input  drop_ready, m_axi4_rready,
        input  s_axi4_rid, s_axi4_rresp, s_axi4_rdata, s_axi4_rlast, s_axi4_rvalid, s_axi4_ruser
    );

endinterface

// File: rtl/axi_buffer_rab.sv
// Small valid/ready FIFO; BUFFER_DEPTH must be a power of two so the pointers wrap naturally.
// ready_out stays high while full if an entry is popped in the same cycle.
module axi_buffer_rab #(
    parameter int DATA_WIDTH   = 18,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_in
);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign valid_out = (r_count != '0);
    assign ready_out = (r_count != FULL_CNT) || ready_in;
    assign w_push    = valid_in && ready_out;
    assign w_pop     = valid_out && ready_in;
    assign data_out  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_r_sender.sv
// Injects SLVERR read bursts for dropped transactions between master bursts on the R channel.
// Define RAB_R_ERR_PATTERN_EN to fill error beats with the DEADBEEF pattern instead of zero.
module axi4_r_sender
    import axi_rab_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 4,
    parameter int DROP_DEPTH     = 4
) (
    input  logic           axi4_aclk,
    input  logic           axi4_arstn,
    axi4_r_sender_if.slave bus
);
    // state   | meaning
    // ST_IDLE | R channel passes through from the master side
    // ST_DROP | emitting error beats for the drop queue head, master held off
    localparam int QW = AXI_ID_WIDTH + 8;

`ifdef RAB_R_ERR_PATTERN_EN
    localparam int NREP = (AXI_DATA_WIDTH + 31) / 32;
    localparam logic [NREP*32-1:0] ERR_REP = {NREP{ERR_DATA_PATTERN}};
    localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA = ERR_REP[AXI_DATA_WIDTH-1:0];
`else
    localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA = '0;
`endif

    r_state_e              r_state;
    logic [7:0]            r_beat_cnt;
    logic                  r_m_burst_active;

    logic [QW-1:0]         w_q_head;
    logic                  w_q_valid;
    logic                  w_q_pop;
    logic [AXI_ID_WIDTH-1:0] w_head_id;
    logic [7:0]            w_head_len;
    logic                  w_err_last;
    logic                  w_m_rready;
    logic                  w_m_hs;
    logic                  w_mstr_idle_next;

    assign {w_head_id, w_head_len} = w_q_head;
    assign w_err_last  = (r_beat_cnt == w_head_len);
    assign w_m_rready  = (r_state == ST_IDLE) && bus.s_axi4_rready;
    assign w_m_hs      = bus.m_axi4_rvalid && w_m_rready;
    assign w_q_pop     = (r_state == ST_DROP) && bus.s_axi4_rready && w_err_last;
    // Safe to switch only when no master burst or unaccepted beat would be cut off
    assign w_mstr_idle_next = (!r_m_burst_active && !bus.m_axi4_rvalid) ||
                              (bus.m_axi4_rvalid && bus.s_axi4_rready && bus.m_axi4_rlast);

    axi_buffer_rab #(
        .DATA_WIDTH   (QW),
        .BUFFER_DEPTH (DROP_DEPTH)
    ) u_drop_q (
        .clk       (axi4_aclk),
        .rstn      (axi4_arstn),
        .valid_in  (bus.trans_drop),
        .data_in   ({bus.trans_id, bus.trans_len}),
        .ready_out (bus.drop_ready),
        .valid_out (w_q_valid),
        .data_out  (w_q_head),
        .ready_in  (w_q_pop)
    );

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_state          <= ST_IDLE;
            r_beat_cnt       <= '0;
            r_m_burst_active <= 1'b0;
        end else begin
            if (w_m_hs) r_m_burst_active <= !bus.m_axi4_rlast;
            case (r_state)
                ST_IDLE: begin
                    if (w_q_valid && w_mstr_idle_next) begin
                        r_state    <= ST_DROP;
                        r_beat_cnt <= '0;
                    end
                end
                ST_DROP: begin
                    if (bus.s_axi4_rready) begin
                        if (w_err_last) r_state <= ST_IDLE;
                        else            r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_axi4_rready = w_m_rready;

    always_comb begin
        bus.s_axi4_rid    = bus.m_axi4_rid;
        bus.s_axi4_rresp  = bus.m_axi4_rresp;
        bus.s_axi4_rdata  = bus.m_axi4_rdata;
        bus.s_axi4_rlast  = bus.m_axi4_rlast;
        bus.s_axi4_rvalid = bus.m_axi4_rvalid;
        bus.s_axi4_ruser  = bus.m_axi4_ruser;
        if (r_state == ST_DROP) begin
            bus.s_axi4_rid    = w_head_id;
            bus.s_axi4_rresp  = RESP_SLVERR;
            bus.s_axi4_rdata  = ERR_DATA;
            bus.s_axi4_rlast  = w_err_last;
            bus.s_axi4_rvalid = 1'b1;
            bus.s_axi4_ruser  = '0;
        end
    end

endmodule

// File: tb/tb_axi4_r_sender.sv
// Directed bench for axi4_r_sender: a drop-queue/beat-stream model checks the R channel every cycle.
module tb_axi4_r_sender;
    localparam int DW = 64, IW = 10, UW = 4, DEPTH = 4;
`ifdef RAB_R_ERR_PATTERN_EN
    localparam logic [DW-1:0] EXP_ERR_DATA = 64'hDEADBEEF_DEADBEEF;
`else
    localparam logic [DW-1:0] EXP_ERR_DATA = 64'h0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi4_r_sender_if #(.AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) bus ();

    axi4_r_sender #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .AXI_USER_WIDTH (UW),
        .DROP_DEPTH     (DEPTH)
    ) dut (
        .axi4_aclk  (clk),
        .axi4_arstn (rst_n),
        .bus        (bus)
    );

    int checks = 0, errors = 0, cyc = 0;
    int mq_id[$], mq_len[$];
    int log_id[$], log_beats[$];
    int beat_idx = 0, cur_beats = 0;
    bit in_err_prev = 0, err_done_prev = 0, m_active = 0, m_pending_prev = 0;
    int m_beats_seen = 0, err_beats_total = 0;
    int last_push_cyc = 0, err_start_cyc = 0, m_last_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_pass();
        chk("pass_ctrl",
            {bus.s_axi4_rvalid, bus.s_axi4_rlast, bus.s_axi4_rresp, bus.s_axi4_ruser, bus.s_axi4_rid},
            {bus.m_axi4_rvalid, bus.m_axi4_rlast, bus.m_axi4_rresp, bus.m_axi4_ruser, bus.m_axi4_rid});
        chk("pass_rdata", bus.s_axi4_rdata, bus.m_axi4_rdata);
        chk("pass_m_rready", bus.m_axi4_rready, bus.s_axi4_rready);
    endtask

    // Model: FIFO of dropped requests; each must appear as len+1 SLVERR beats, only between master bursts
    initial begin
        bit is_err, pop, exp_dr;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mq_id.delete(); mq_len.delete();
                beat_idx = 0; cur_beats = 0;
                in_err_prev = 0; err_done_prev = 0; m_active = 0; m_pending_prev = 0;
                chk("rst_drop_ready", bus.drop_ready, 1);
                chk_pass();
            end else begin
                is_err = bus.s_axi4_rvalid && (bus.s_axi4_rresp == 2'b10);
                pop = 0;
                exp_dr = (mq_id.size() < DEPTH) ||
                         (is_err && bus.s_axi4_rready && mq_id.size() > 0 && beat_idx == mq_len[0]);
                chk("drop_ready", bus.drop_ready, exp_dr);
                if (in_err_prev && !err_done_prev) chk("err_burst_continues", is_err, 1);
                if (is_err) begin
                    chk("err_has_entry", mq_id.size() != 0, 1);
                    if (mq_id.size() != 0) begin
                        if (!in_err_prev || err_done_prev) begin
                            chk("err_start_legal", {m_active, m_pending_prev, err_done_prev}, 0);
                            err_start_cyc = cyc;
                        end
                        chk("err_rid", bus.s_axi4_rid, mq_id[0]);
                        chk("err_rlast", bus.s_axi4_rlast, beat_idx == mq_len[0]);
                        chk("err_rdata", bus.s_axi4_rdata, EXP_ERR_DATA);
                        chk("err_ruser", bus.s_axi4_ruser, 0);
                        chk("err_m_rready", bus.m_axi4_rready, 0);
                        if (bus.s_axi4_rready) begin
                            err_beats_total++;
                            cur_beats++;
                            if (beat_idx == mq_len[0]) begin
                                log_id.push_back(mq_id[0]);
                                log_beats.push_back(cur_beats);
                                void'(mq_id.pop_front());
                                void'(mq_len.pop_front());
                                beat_idx = 0; cur_beats = 0; pop = 1;
                            end else begin
                                beat_idx++;
                            end
                        end
                    end
                end else begin
                    chk_pass();
                end
                if (bus.m_axi4_rvalid && bus.m_axi4_rready) begin
                    m_beats_seen++;
                    m_active = !bus.m_axi4_rlast;
                    if (bus.m_axi4_rlast) m_last_cyc = cyc;
                end
                m_pending_prev = bus.m_axi4_rvalid && !bus.m_axi4_rready;
                if (bus.trans_drop && bus.drop_ready) begin
                    mq_id.push_back(int'(bus.trans_id));
                    mq_len.push_back(int'(bus.trans_len));
                    last_push_cyc = cyc;
                end
                in_err_prev = is_err;
                err_done_prev = pop;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_drop(input int id, input int len, output int waits);
        bit acc;
        waits = -1;
        bus.trans_id = IW'(id);
        bus.trans_len = 8'(len);
        bus.trans_drop = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            acc = bus.drop_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                waits = n;
                break;
            end
        end
        bus.trans_drop = 1'b0;
        chk("drop_accepted", waits >= 0, 1);
    endtask

    task automatic master_burst(input int id, input int len, input int base);
        bit hs;
        for (int i = 0; i <= len; i++) begin
            bus.m_axi4_rvalid = 1'b1;
            bus.m_axi4_rid = IW'(id);
            bus.m_axi4_rdata = DW'(base + i);
            bus.m_axi4_rlast = (i == len);
            bus.m_axi4_ruser = UW'(i);
            bus.m_axi4_rresp = 2'b00;
            hs = 0;
            for (int n = 0; n < 2000 && !hs; n++) begin
                @(negedge clk);
                hs = bus.m_axi4_rready;
                @(posedge clk);
                #1;
            end
            chk("master_beat_accepted", hs, 1);
        end
        bus.m_axi4_rvalid = 1'b0;
        bus.m_axi4_rlast = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input int budget, input string name);
        for (int n = 0; n < budget && log_id.size() < target; n++) @(posedge clk);
        #1;
        chk(name, log_id.size(), target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int w, base, n_pushed, err_before;
        int t4_ids[5];
        int t4_beats[5];
        bit acc;
        t4_ids = '{'h40, 'h41, 'h42, 'h43, 'h50};
        t4_beats = '{1, 2, 1, 2, 1};
        rst_n = 1'b0;
        bus.trans_id = '0; bus.trans_len = '0; bus.trans_drop = 1'b0;
        bus.s_axi4_rready = 1'b0;
        bus.m_axi4_rid = '0; bus.m_axi4_rresp = '0; bus.m_axi4_rdata = '0;
        bus.m_axi4_rlast = 1'b0; bus.m_axi4_rvalid = 1'b0; bus.m_axi4_ruser = '0;
        step(3);
        @(negedge clk);
        chk("reset_drop_ready", bus.drop_ready, 1);
        chk("reset_s_rvalid", bus.s_axi4_rvalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);

        // Single drop, idle master
        bus.s_axi4_rready = 1'b1;
        do_drop('h15, 3, w);
        wait_bursts(1, 50, "t1_done");
        chk("t1_id", log_id[0], 'h15);
        chk("t1_beats", log_beats[0], 4);
        chk("t1_latency", err_start_cyc - last_push_cyc, 2);

        // Drop arrives mid master burst
        step(2);
        base = m_beats_seen;
        fork
            master_burst('h33, 7, 'h100);
            begin
                for (int n = 0; n < 100 && m_beats_seen < base + 3; n++) @(posedge clk);
                #1;
                do_drop('h2, 0, w);
            end
        join
        wait_bursts(2, 100, "t2_done");
        chk("t2_master_beats", m_beats_seen - base, 8);
        chk("t2_id", log_id[1], 'h2);
        chk("t2_beats", log_beats[1], 1);
        chk("t2_err_after_master", err_start_cyc > m_last_cyc, 1);

        // Backpressure holds the first error beat
        step(2);
        bus.s_axi4_rready = 1'b0;
        do_drop('h7, 1, w);
        step(5);
        @(negedge clk);
        chk("t3_hold_valid", bus.s_axi4_rvalid, 1);
        chk("t3_hold_rlast", bus.s_axi4_rlast, 0);
        chk("t3_hold_rid", bus.s_axi4_rid, 'h7);
        chk("t3_m_rready", bus.m_axi4_rready, 0);
        @(posedge clk); #1;
        bus.s_axi4_rready = 1'b1;
        wait_bursts(3, 50, "t3_done");
        chk("t3_beats", log_beats[2], 2);

        // Fill the queue, then push in the same cycle as the first pop
        step(2);
        bus.s_axi4_rready = 1'b0;
        n_pushed = 0;
        for (int k = 0; k < 8; k++) begin
            bus.trans_id = IW'('h40 + k);
            bus.trans_len = 8'(k % 2);
            bus.trans_drop = 1'b1;
            @(negedge clk);
            acc = bus.drop_ready;
            if (!acc) break;
            n_pushed++;
            @(posedge clk); #1;
        end
        bus.trans_drop = 1'b0;
        chk("t4_fill_count", n_pushed, DEPTH);
        @(posedge clk); #1;
        bus.s_axi4_rready = 1'b1;
        do_drop('h50, 0, w);
        chk("t4_push_on_pop_wait", w, 0);
        wait_bursts(8, 300, "t4_done");
        for (int i = 0; i < 5; i++) begin
            chk("t4_order_id", log_id[3 + i], t4_ids[i]);
            chk("t4_order_beats", log_beats[3 + i], t4_beats[i]);
        end

        // Maximum length burst
        step(2);
        do_drop('h1A5, 255, w);
        wait_bursts(9, 400, "t5_done");
        chk("t5_id", log_id[8], 'h1A5);
        chk("t5_beats", log_beats[8], 256);

        // Reset in the middle of an error burst
        step(2);
        do_drop('h66, 5, w);
        for (int n = 0; n < 50 && cur_beats < 1; n++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        err_before = err_beats_total;
        @(negedge clk);
        chk("t6_rst_s_rvalid", bus.s_axi4_rvalid, 0);
        chk("t6_rst_m_rready", bus.m_axi4_rready, 1);
        chk("t6_rst_drop_ready", bus.drop_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(10);
        chk("t6_no_more_err", err_beats_total - err_before, 0);
        chk("t6_log_unchanged", log_id.size(), 9);
        chk("final_queue_empty", mq_id.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_r_sender.md
AXI4_R_SENDER -- requirements
Module: axi4_r_sender

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64, width of R data.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 10, width of transaction ID.
REQ-003 SHALL have parameter AXI_USER_WIDTH, default 4, width of R user.
REQ-004 SHALL use one clock and an asynchronous active-low reset: axi4_aclk in 1, rising-edge clock; axi4_arstn in 1, reset.
REQ-005 SHALL have ports:
- trans_id  in  AXI_ID_WIDTH  ID of the dropped read.
- trans_len  in  8  ARLEN of the dropped read.
- trans_drop  in  1  request to queue an error response.
- drop_ready  out  1  drop queue not full.
- s_axi4_rid / rresp / rdata / rlast / rvalid / ruser  out  ID / 2 / DATA / 1 / 1 / USER  slave-side R channel.
- s_axi4_rready  in  1  slave-side R ready.
- m_axi4_rid / rresp / rdata / rlast / rvalid / ruser  in  ID / 2 / DATA / 1 / 1 / USER  master-side R channel.
- m_axi4_rready  out  1  master-side R ready.

Function
REQ-006 SHALL push {trans_id, trans_len} into the drop queue only on trans_drop && drop_ready; upstream holds trans_drop until drop_ready.
REQ-007 SHALL track m_burst_active: set on master beat handshake with rlast=0, cleared on handshake with rlast=1.
REQ-008 SHALL define mstr_idle_next = (!m_burst_active && !m_axi4_rvalid) || (m_axi4_rvalid && s_axi4_rready && m_axi4_rlast).
REQ-009 SHALL implement FSM IDLE/DROP; IDLE->DROP when queue non-empty && mstr_idle_next; beat_cnt cleared on entry.
REQ-010 In IDLE SHALL pass all s_axi4_r* outputs from m_axi4_r* and drive m_axi4_rready = s_axi4_rready.
REQ-011 In DROP SHALL drive s_axi4_rvalid=1, rid=queue head ID, rresp=2'b10 (SLVERR), ruser=0, rlast=(beat_cnt==head len), m_axi4_rready=0.
REQ-012 In DROP SHALL increment beat_cnt on s_axi4_rready when rlast=0; on s_axi4_rready with rlast=1, pop the queue and return to IDLE.
REQ-013 SHALL emit exactly trans_len+1 error beats; len 255 yields 256 beats, 8-bit counter never wraps within a burst.
REQ-014 SHALL keep DROP outputs stable while s_axi4_rready=0; never interrupt a master burst or an unaccepted master beat.
REQ-015 SHALL spend at least one IDLE cycle between consecutive dropped bursts; first error beat earliest 2 cycles after trans_drop.
REQ-016 SHALL accept a push in the same cycle as a pop; drop_ready SHALL stay high then.

Reset
REQ-017 On axi4_arstn=0 SHALL force IDLE, beat_cnt=0, m_burst_active=0, drop queue empty, drop_ready=1; R outputs pass through per REQ-010.
REQ-018 Reset mid-DROP SHALL abandon the burst and discard all queued entries.

Configuration
REQ-019 With RAB_R_ERR_PATTERN_EN defined, error beats SHALL carry rdata = 32'hDEADBEEF replicated to AXI_DATA_WIDTH, truncated if narrower; undefined, rdata=0.

Structure
REQ-020 SHALL take RESP_SLVERR (2'b10) and ERR_DATA_PATTERN (32'hDEADBEEF) from shared package axi_rab_pkg.
REQ-021 SHALL implement the drop queue with one instance of axi_buffer_rab, DATA_WIDTH=AXI_ID_WIDTH+8.

Verification
REQ-022 Drop id=0x15 len=3, master idle, rready=1 -> 4 beats rid=0x15, rresp=2'b10, rlast on beat 4 only.
REQ-023 Master burst len=7 in flight, drop id=0x2 len=0 at beat 3 -> all 8 master beats intact, then 1 error beat rlast=1.
REQ-024 DROP len=1 with rready low 5 cycles -> beat 1 held stable, m_axi4_rready=0, counter unchanged.
REQ-025 Fill queue until drop_ready=0, then drain -> entries returned in FIFO order, drop_ready back to 1 after first pop.
REQ-026 Drop len=255 -> exactly 256 beats, rlast only on beat 256; rdata=DEADBEEF pattern iff RAB_R_ERR_PATTERN_EN.
REQ-027 Reset asserted at beat 2 of len=5 drop -> next cycle IDLE, pass-through, no further error beats.
